mem_store_unit: RTL and testbench
=================================

MEM_STORE_UNIT -- requirements
Module: mem_store_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 2, store-buffer entries (power of 2, >=2).
REQ-002 SHALL have parameter CPU_WIDTH, default 32, address/data width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port st_valid  input  1  store request valid.
REQ-006 SHALL have port st_ready  output  1  unit can accept a store.
REQ-007 SHALL have port st_op  input  MEM_OP_WIDTH  memory opcode (MEM_SB/MEM_SH/MEM_SW from the core defines).
REQ-008 SHALL have port st_addr  input  CPU_WIDTH  byte address of store.
REQ-009 SHALL have port st_data  input  CPU_WIDTH  register data, right-justified.
REQ-010 SHALL have port st_misalign  output  1  one-cycle pulse, misaligned store dropped.
REQ-011 SHALL have port mem_wen  output  1  memory write request valid.
REQ-012 SHALL have port mem_waddr  output  CPU_WIDTH  word-aligned write address.
REQ-013 SHALL have port mem_wdata  output  CPU_WIDTH  lane-aligned write data.
REQ-014 SHALL have port mem_wstrb  output  4  byte-lane write enables.
REQ-015 SHALL have port mem_wack  input  1  memory accepted current write.
REQ-016 SHALL have port ld_addr  input  CPU_WIDTH  address of an in-flight load.
REQ-017 SHALL have port ld_hazard  output  1  buffered store overlaps ld_addr word.
REQ-018 SHALL have port st_empty  output  1  buffer holds no pending stores.

Function
REQ-019 Handshake: a store SHALL be accepted in a cycle where st_valid=1 and st_ready=1; st_ready SHALL equal !full, with no same-cycle push-through when full, even if mem_wack pops.
REQ-020 MEM_SB: wstrb = 4'b0001 << addr[1:0]; wdata = st_data[7:0] replicated in all 4 lanes; never misaligned.
REQ-021 MEM_SH: addr[0] must be 0; wstrb = addr[1] ? 4'b1100 : 4'b0011; wdata = st_data[15:0] replicated in both halves.
REQ-022 MEM_SW: addr[1:0] must be 00; wstrb = 4'b1111; wdata = st_data.
REQ-023 Any other st_op SHALL be consumed (handshake completes) but neither enqueued nor flagged.
REQ-024 Misaligned accepted store SHALL NOT be enqueued; st_misalign SHALL be 1 exactly in the cycle after acceptance (registered).
REQ-025 Enqueued entry SHALL store {addr[31:2],2'b00}, aligned wdata, wstrb.
REQ-026 Buffer SHALL be FIFO, read/write pointers log2(DEPTH)+1 bits, wrap modulo 2*DEPTH; full when indices equal and MSBs differ, empty when pointers equal.
REQ-027 mem_wen SHALL equal !empty; mem_waddr/mem_wdata/mem_wstrb SHALL present the head entry and hold stable until mem_wack=1 with mem_wen=1.
REQ-028 mem_wack with mem_wen=1 SHALL pop the head at that edge; mem_wack with mem_wen=0 SHALL be ignored.
REQ-029 Latency: store accepted into an empty buffer at edge N SHALL drive mem_wen=1 in the cycle after edge N; minimum one store per cycle throughput when mem_wack held high.
REQ-030 Simultaneous push and pop (not full) SHALL leave count unchanged and preserve order.
REQ-031 ld_hazard SHALL be combinational: 1 iff any valid entry's word address equals ld_addr[31:2]; 0 when empty.
REQ-032 st_empty SHALL equal empty.

Reset
REQ-033 On rst=1 pointers SHALL clear immediately; mem_wen=0, mem_waddr=0, mem_wdata=0, mem_wstrb=0, st_misalign=0, ld_hazard=0, st_empty=1, st_ready=1.
REQ-034 Reset asserted mid-transfer SHALL discard all pending entries; no write issues after deassertion without a new store.

Verification
REQ-035 SB addr=0x1003 data=0x000000A5, mem_wack=1 -> next cycle mem_wen=1, waddr=0x1000, wdata=0xA5A5A5A5, wstrb=1000.
REQ-036 SH addr=0x2002 data=0x1234BEEF -> waddr=0x2000, wdata=0xBEEFBEEF, wstrb=1100; SW addr=0x3000 -> wstrb=1111, wdata unchanged.
REQ-037 SW addr=0x4001 -> st_misalign=1 one cycle, mem_wen stays 0, st_empty stays 1.
REQ-038 mem_wack=0, push DEPTH stores -> st_ready=0, st_valid held; release mem_wack -> writes emerge in order, one per cycle, then st_ready=1.
REQ-039 Buffer holds store to 0x5004, ld_addr=0x5007 -> ld_hazard=1; ld_addr=0x5008 -> ld_hazard=0.
REQ-040 Two stores pending, assert rst one cycle -> mem_wen=0 immediately, st_empty=1, no writes after release.

Source files
------------

// File: rtl/mem_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_store_unit
// Purpose  : Store path of the load/store unit. Accepts byte/half/word store
//            requests, checks natural alignment, lane-aligns data and byte
//            strobes, and queues the result in a small FIFO store buffer that
//            drains to memory one write per mem_wack. A combinational
//            word-address compare against ld_addr reports load/store hazards.
// Ports    : clk, rst                   clock, async active-high reset
//            st_valid/st_ready          store request handshake
//            st_op/st_addr/st_data      store opcode, byte address, raw data
//            st_misalign                one-cycle pulse, misaligned store dropped
//            mem_wen/mem_waddr/
//            mem_wdata/mem_wstrb        head-of-buffer write request
//            mem_wack                   memory accepted current write
//            ld_addr/ld_hazard          in-flight load address / overlap flag
//            st_empty                   buffer holds no pending stores
// Revision : 1.0 - initial release
// ============================================================================
module mem_store_unit #(
    parameter int DEPTH        = 2,
    parameter int CPU_WIDTH    = 32,
    parameter int MEM_OP_WIDTH = 4,
    parameter logic [MEM_OP_WIDTH-1:0] MEM_SB = 4'h8,
    parameter logic [MEM_OP_WIDTH-1:0] MEM_SH = 4'h9,
    parameter logic [MEM_OP_WIDTH-1:0] MEM_SW = 4'hA
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    st_valid,
    output logic                    st_ready,
    input  logic [MEM_OP_WIDTH-1:0] st_op,
    input  logic [CPU_WIDTH-1:0]    st_addr,
    input  logic [CPU_WIDTH-1:0]    st_data,
    output logic                    st_misalign,
    output logic                    mem_wen,
    output logic [CPU_WIDTH-1:0]    mem_waddr,
    output logic [CPU_WIDTH-1:0]    mem_wdata,
    output logic [3:0]              mem_wstrb,
    input  logic                    mem_wack,
    input  logic [CPU_WIDTH-1:0]    ld_addr,
    output logic                    ld_hazard,
    output logic                    st_empty
);

    localparam int c_AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [c_AW:0]          r_wr_ptr;
    logic [c_AW:0]          r_rd_ptr;
    logic [c_AW:0]          w_count;
    logic [c_AW-1:0]        w_wr_idx;
    logic [c_AW-1:0]        w_rd_idx;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_accept;
    logic                   w_push;
    logic                   w_pop;
    logic                   r_misalign;

    logic                   w_op_known;
    logic                   w_misalign;
    logic [3:0]             w_strb;
    logic [CPU_WIDTH-1:0]   w_data;
    logic [CPU_WIDTH-1:0]   w_addr_al;

    logic [CPU_WIDTH-1:0]   r_addr_q [DEPTH];
    logic [CPU_WIDTH-1:0]   r_data_q [DEPTH];
    logic [3:0]             r_strb_q [DEPTH];

    logic [DEPTH-1:0]       w_hit;

    assign w_wr_idx = r_wr_ptr[c_AW-1:0];
    assign w_rd_idx = r_rd_ptr[c_AW-1:0];
    assign w_count  = r_wr_ptr - r_rd_ptr;
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) && (w_wr_idx == w_rd_idx);

    // Ready depends only on the current fill level: a pop in the same cycle
    // does not open a slot until the following cycle.
    assign st_ready = !w_full;
    assign w_accept = st_valid && !w_full;
    assign w_push   = w_accept && w_op_known && !w_misalign;
    assign w_pop    = mem_wack && !w_empty;

    assign w_addr_al = {st_addr[CPU_WIDTH-1:2], 2'b00};

    // Opcode decode, alignment check and lane placement.
    always_comb begin
        w_op_known = 1'b1;
        w_misalign = 1'b0;
        w_strb     = 4'b0000;
        w_data     = '0;
        case (st_op)
            MEM_SB: begin
                w_strb = 4'b0001 << st_addr[1:0];
                w_data = {4{st_data[7:0]}};
            end
            MEM_SH: begin
                w_misalign = st_addr[0];
                w_strb     = st_addr[1] ? 4'b1100 : 4'b0011;
                w_data     = {2{st_data[15:0]}};
            end
            MEM_SW: begin
                w_misalign = |st_addr[1:0];
                w_strb     = 4'b1111;
                w_data     = st_data;
            end
            default: begin
                // Unknown opcodes complete the handshake and are discarded.
                w_op_known = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_misalign <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_misalign <= w_accept && w_op_known && w_misalign;
        end
    end

    // Entry storage needs no reset: every read of it is qualified by the
    // pointer state, which is reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr_q[w_wr_idx] <= w_addr_al;
            r_data_q[w_wr_idx] <= w_data;
            r_strb_q[w_wr_idx] <= w_strb;
        end
    end

    // An entry is live when its distance from the read index is below the
    // fill count; only live entries take part in the hazard compare.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
        logic [c_AW-1:0] w_off;
        assign w_off     = c_AW'(gi) - w_rd_idx;
        assign w_hit[gi] = ({1'b0, w_off} < w_count) &&
                           (r_addr_q[gi][CPU_WIDTH-1:2] == ld_addr[CPU_WIDTH-1:2]);
    end

    assign ld_hazard   = |w_hit;
    assign st_misalign = r_misalign;
    assign st_empty    = w_empty;
    assign mem_wen     = !w_empty;
    assign mem_waddr   = w_empty ? '0 : r_addr_q[w_rd_idx];
    assign mem_wdata   = w_empty ? '0 : r_data_q[w_rd_idx];
    assign mem_wstrb   = w_empty ? 4'b0000 : r_strb_q[w_rd_idx];

endmodule
`default_nettype wire

// File: tb/tb_mem_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_store_unit
// Purpose  : Self-checking bench for mem_store_unit. Expected memory writes
//            are queued when a store is accepted and compared in order as the
//            memory acknowledges them; misalign pulses are predicted from the
//            accepted request.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_store_unit;

    localparam int         c_DEPTH = 2;
    localparam logic [3:0] c_SB    = 4'h8;
    localparam logic [3:0] c_SH    = 4'h9;
    localparam logic [3:0] c_SW    = 4'hA;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid;
    logic        st_ready;
    logic [3:0]  st_op;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_misalign;
    logic        mem_wen;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_wack;
    logic [31:0] ld_addr;
    logic        ld_hazard;
    logic        st_empty;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    wr_t  sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    logic mis_prev = 1'b0;

    mem_store_unit #(
        .DEPTH(c_DEPTH),
        .CPU_WIDTH(32),
        .MEM_OP_WIDTH(4),
        .MEM_SB(c_SB),
        .MEM_SH(c_SH),
        .MEM_SW(c_SW)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .st_valid(st_valid),
        .st_ready(st_ready),
        .st_op(st_op),
        .st_addr(st_addr),
        .st_data(st_data),
        .st_misalign(st_misalign),
        .mem_wen(mem_wen),
        .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_wack(mem_wack),
        .ld_addr(ld_addr),
        .ld_hazard(ld_hazard),
        .st_empty(st_empty)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_mis(input logic [3:0] op, input logic [31:0] a);
        if (op == c_SH) return a[0];
        if (op == c_SW) return (a[1:0] != 2'b00);
        return 1'b0;
    endfunction

    function automatic logic model_enq(input logic [3:0] op, input logic [31:0] a);
        return ((op == c_SB) || (op == c_SH) || (op == c_SW)) && !model_mis(op, a);
    endfunction

    function automatic wr_t model_wr(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a & 32'hFFFF_FFFC;
        w.data = d;
        w.strb = 4'hF;
        if (op == c_SB) begin
            w.data = {d[7:0], d[7:0], d[7:0], d[7:0]};
            case (a[1:0])
                2'd0:    w.strb = 4'b0001;
                2'd1:    w.strb = 4'b0010;
                2'd2:    w.strb = 4'b0100;
                default: w.strb = 4'b1000;
            endcase
        end else if (op == c_SH) begin
            w.data = {d[15:0], d[15:0]};
            w.strb = a[1] ? 4'b1100 : 4'b0011;
        end
        return w;
    endfunction

    // Scoreboard: retire acknowledged writes first, then record this cycle's
    // accepted store (it can only reach the memory port after the next edge).
    always @(negedge clk) begin
        wr_t e;
        if (rst) begin
            sb.delete();
            mis_prev = 1'b0;
        end else begin
            check("misalign", st_misalign, mis_prev);
            if (mem_wen && mem_wack) begin
                if (sb.size() == 0) begin
                    check("spurious_write", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("waddr", mem_waddr, e.addr);
                    check("wdata", mem_wdata, e.data);
                    check("wstrb", mem_wstrb, e.strb);
                end
            end
            mis_prev = st_valid && st_ready && model_mis(st_op, st_addr);
            if (st_valid && st_ready && model_enq(st_op, st_addr))
                sb.push_back(model_wr(st_op, st_addr, st_data));
        end
    end

    // Present a store, wait (bounded) for acceptance, return #1 after the
    // accepting edge. With hold=1 st_valid is left high for a back-to-back store.
    task automatic do_store(input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] d, input bit hold);
        bit ok = 0;
        st_valid = 1'b1;
        st_op    = op;
        st_addr  = a;
        st_data  = d;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (st_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (!hold) st_valid = 1'b0;
    endtask

    initial begin
        int t0;
        rst      = 1'b1;
        st_valid = 1'b0;
        st_op    = 4'h0;
        st_addr  = '0;
        st_data  = '0;
        mem_wack = 1'b0;
        ld_addr  = '0;
        #2;
        check("rst_wen", mem_wen, 0);
        check("rst_waddr", mem_waddr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_wstrb", mem_wstrb, 0);
        check("rst_misalign", st_misalign, 0);
        check("rst_hazard", ld_hazard, 0);
        check("rst_empty", st_empty, 1);
        check("rst_ready", st_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Byte store into an empty buffer: write visible the next cycle.
        mem_wack = 1'b1;
        do_store(c_SB, 32'h0000_1003, 32'h0000_00A5, 0);
        @(negedge clk);
        check("sb_latency_wen", mem_wen, 1);
        check("sb_waddr", mem_waddr, 32'h1000);
        check("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
        check("sb_wstrb", mem_wstrb, 4'b1000);

        do_store(c_SH, 32'h0000_2002, 32'h1234_BEEF, 0);
        @(negedge clk);
        check("sh_waddr", mem_waddr, 32'h2000);
        check("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
        check("sh_wstrb", mem_wstrb, 4'b1100);

        do_store(c_SW, 32'h0000_3000, 32'hDEAD_BEEF, 0);
        @(negedge clk);
        check("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("sw_wstrb", mem_wstrb, 4'b1111);

        // Misaligned word: dropped, one-cycle pulse.
        @(negedge clk);
        do_store(c_SW, 32'h0000_4001, 32'h1111_2222, 0);
        @(negedge clk);
        check("mis_pulse", st_misalign, 1);
        check("mis_no_wen", mem_wen, 0);
        check("mis_empty", st_empty, 1);
        @(negedge clk);
        check("mis_pulse_end", st_misalign, 0);

        // Misaligned half and an unknown opcode: neither is queued.
        do_store(c_SH, 32'h0000_4101, 32'h3333_4444, 0);
        do_store(4'h0, 32'h0000_4200, 32'h5555_6666, 0);
        @(negedge clk);
        check("unk_empty", st_empty, 1);
        check("unk_no_wen", mem_wen, 0);
        check("unk_no_mis", st_misalign, 0);

        // Fill with memory stalled, then hold a further store against full.
        @(posedge clk);
        #1 mem_wack = 1'b0;
        for (int i = 0; i < c_DEPTH; i++)
            do_store(c_SW, 32'h0000_6000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 0);
        st_valid = 1'b1;
        st_op    = c_SW;
        st_addr  = 32'h0000_6000 + 32'(4 * c_DEPTH);
        st_data  = 32'hA000_00FF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_ready", st_ready, 0);
            check("full_head_stable", mem_waddr, 32'h6000);
        end
        @(posedge clk);
        #1 mem_wack = 1'b1;
        @(negedge clk);
        check("full_no_pushthrough", st_ready, 0);
        do_store(c_SW, 32'h0000_6000 + 32'(4 * c_DEPTH), 32'hA000_00FF, 0);
        repeat (c_DEPTH + 1) @(negedge clk);
        check("drain_empty", st_empty, 1);
        check("drain_ready", st_ready, 1);

        // Back-to-back stores with mem_wack high: one accepted per cycle.
        @(posedge clk);
        #1;
        t0 = cyc;
        for (int i = 0; i < 4; i++)
            do_store(c_SB, 32'h0000_8000 + 32'(i), 32'h0000_0010 + 32'(i), i < 3);
        check("throughput_cycles", cyc - t0, 4);
        repeat (3) @(negedge clk);

        // Load hazard against a buffered word.
        @(posedge clk);
        #1 mem_wack = 1'b0;
        do_store(c_SW, 32'h0000_5004, 32'hCAFE_F00D, 0);
        ld_addr = 32'h0000_5007;
        #1 check("hazard_hit", ld_hazard, 1);
        ld_addr = 32'h0000_5008;
        #1 check("hazard_miss", ld_hazard, 0);
        ld_addr = 32'h0000_5004;
        @(posedge clk);
        #1 mem_wack = 1'b1;
        repeat (2) @(negedge clk);
        check("hazard_empty", ld_hazard, 0);

        // Reset mid-transfer with two pending stores.
        @(posedge clk);
        #1 mem_wack = 1'b0;
        do_store(c_SW, 32'h0000_7000, 32'h7777_0000, 0);
        do_store(c_SW, 32'h0000_7004, 32'h7777_0004, 0);
        @(negedge clk);
        check("pre_rst_wen", mem_wen, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_wen", mem_wen, 0);
        check("rst_mid_empty", st_empty, 1);
        check("rst_mid_ready", st_ready, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        mem_wack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_no_wen", mem_wen, 0);
        end

        repeat (2) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
